mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage: drives the data cache, stalls on miss, writes the MEM/WB latch.
// Define MEM_TIMEOUT_EN to add the WAIT watchdog and its mem_timeout output.
module mem_stage (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        exmem_valid,
   input  logic        exmem_dmemREN,
   input  logic        exmem_dmemWEN,
   input  logic        exmem_regwen,
   input  logic        exmem_halt,
   input  logic [31:0] exmem_porto,
   input  logic [31:0] exmem_rdat2,
   input  logic [31:0] exmem_extimm,
   input  logic [31:0] exmem_npc,
   input  logic [4:0]  exmem_wsel,
   input  logic [1:0]  exmem_regsrc,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   input  logic        dhit,
   input  logic [31:0] dmemload,
   input  logic        flush,
   output logic        mem_stall,
   output logic        memwb_valid,
   output logic        memwb_regwen,
   output logic [4:0]  memwb_wsel,
   output logic [31:0] memwb_wdat,
   output logic        memwb_halt
`ifdef MEM_TIMEOUT_EN
   ,
   output logic        mem_timeout
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

   state_t      state;
   logic [31:0] c_addr, c_store, c_npc, c_extimm;
   logic [4:0]  c_wsel;
   logic [1:0]  c_regsrc;
   logic        c_ren, c_wen, c_regwen, c_halt;
   logic        flush_r;
   logic        memop, ren_i, wen_i, kill;

   function automatic logic [31:0] pick(
      input logic [1:0]  src,
      input logic [31:0] alu,
      input logic [31:0] ld,
      input logic [31:0] npc,
      input logic [31:0] imm
   );
      logic [31:0] r;
      case (src)
         2'd0:    r = alu;
         2'd1:    r = ld;
         2'd2:    r = npc;
         default: r = imm;
      endcase
      return r;
   endfunction

   // A load wins over a simultaneous store request.
   assign memop = exmem_valid & (exmem_dmemREN | exmem_dmemWEN);
   assign ren_i = memop & exmem_dmemREN;
   assign wen_i = memop & exmem_dmemWEN & ~exmem_dmemREN;
   assign kill  = flush | flush_r;

   // Request enables are gated by nRST so they fall with reset itself.
   always_comb begin
      dmemREN   = 1'b0;
      dmemWEN   = 1'b0;
      dmemaddr  = '0;
      dmemstore = '0;
      mem_stall = 1'b0;
      case (state)
         IDLE: begin
            dmemREN   = nRST & ren_i;
            dmemWEN   = nRST & wen_i;
            dmemaddr  = exmem_porto;
            dmemstore = exmem_rdat2;
            mem_stall = memop & ~dhit;
         end
         WAIT: begin
            dmemREN   = nRST & c_ren;
            dmemWEN   = nRST & c_wen;
            dmemaddr  = c_addr;
            dmemstore = c_store;
            mem_stall = ~dhit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state        <= IDLE;
         c_addr       <= '0;
         c_store      <= '0;
         c_npc        <= '0;
         c_extimm     <= '0;
         c_wsel       <= '0;
         c_regsrc     <= '0;
         c_ren        <= 1'b0;
         c_wen        <= 1'b0;
         c_regwen     <= 1'b0;
         c_halt       <= 1'b0;
         flush_r      <= 1'b0;
         memwb_valid  <= 1'b0;
         memwb_regwen <= 1'b0;
         memwb_wsel   <= '0;
         memwb_wdat   <= '0;
         memwb_halt   <= 1'b0;
      end else begin
         memwb_valid  <= 1'b0;
         memwb_regwen <= 1'b0;
         case (state)
            IDLE: begin
               if (memop & ~dhit) begin
                  c_addr   <= exmem_porto;
                  c_store  <= exmem_rdat2;
                  c_npc    <= exmem_npc;
                  c_extimm <= exmem_extimm;
                  c_wsel   <= exmem_wsel;
                  c_regsrc <= exmem_regsrc;
                  c_ren    <= ren_i;
                  c_wen    <= wen_i;
                  c_regwen <= exmem_regwen;
                  c_halt   <= exmem_halt;
                  flush_r  <= flush;
                  state    <= WAIT;
               end else if (exmem_valid) begin
                  memwb_valid  <= ~flush;
                  memwb_regwen <= exmem_regwen & ~flush;
                  memwb_wsel   <= exmem_wsel;
                  memwb_wdat   <= pick(exmem_regsrc, exmem_porto,
                                       dmemload, exmem_npc,
                                       exmem_extimm);
                  if (exmem_halt & ~flush) begin
                     memwb_halt <= 1'b1;
                     state      <= HALTED;
                  end
               end
            end
            WAIT: begin
               if (dhit) begin
                  memwb_valid  <= ~kill;
                  memwb_regwen <= c_regwen & ~kill;
                  memwb_wsel   <= c_wsel;
                  memwb_wdat   <= pick(c_regsrc, c_addr, dmemload,
                                       c_npc, c_extimm);
                  flush_r      <= 1'b0;
                  if (c_halt & ~kill) begin
                     memwb_halt <= 1'b1;
                     state      <= HALTED;
                  end else begin
                     state <= IDLE;
                  end
               end else if (flush) begin
                  flush_r <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   logic [7:0] wait_cnt;

   // Flag raised on the edge where the count of WAIT cycles hits 255.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (state == WAIT && !dhit) begin
         if (wait_cnt != 8'hff) wait_cnt <= wait_cnt + 8'd1;
         if (wait_cnt == 8'hfe) mem_timeout <= 1'b1;
      end else begin
         wait_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random traffic
// checked against a transaction-level model of the stage.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        exmem_valid, exmem_dmemREN, exmem_dmemWEN;
   logic        exmem_regwen, exmem_halt;
   logic [31:0] exmem_porto, exmem_rdat2, exmem_extimm, exmem_npc;
   logic [4:0]  exmem_wsel;
   logic [1:0]  exmem_regsrc;
   logic        dmemREN, dmemWEN;
   logic [31:0] dmemaddr, dmemstore;
   logic        dhit;
   logic [31:0] dmemload;
   logic        flush, mem_stall;
   logic        memwb_valid, memwb_regwen, memwb_halt;
   logic [4:0]  memwb_wsel;
   logic [31:0] memwb_wdat;
`ifdef MEM_TIMEOUT_EN
   logic        mem_timeout;
`endif

   always #5 CLK = ~CLK;

   mem_stage dut (
      .CLK(CLK), .nRST(nRST),
      .exmem_valid(exmem_valid), .exmem_dmemREN(exmem_dmemREN),
      .exmem_dmemWEN(exmem_dmemWEN), .exmem_regwen(exmem_regwen),
      .exmem_halt(exmem_halt), .exmem_porto(exmem_porto),
      .exmem_rdat2(exmem_rdat2), .exmem_extimm(exmem_extimm),
      .exmem_npc(exmem_npc), .exmem_wsel(exmem_wsel),
      .exmem_regsrc(exmem_regsrc),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
      .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
      .flush(flush), .mem_stall(mem_stall),
      .memwb_valid(memwb_valid), .memwb_regwen(memwb_regwen),
      .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
      .memwb_halt(memwb_halt)
`ifdef MEM_TIMEOUT_EN
      , .mem_timeout(mem_timeout)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One memory transaction as the model sees it.
   typedef struct packed {
      logic        ren, wen, regwen, halt;
      logic [1:0]  regsrc;
      logic [4:0]  wsel;
      logic [31:0] addr, store, npc, imm;
   } req_t;

   req_t        pend_q[$];
   bit          m_kill, m_halt;
   logic        e_valid, e_regwen, e_halt;
   logic [4:0]  e_wsel;
   logic [31:0] e_wdat;

   function automatic req_t from_in();
      req_t r;
      r.ren    = exmem_valid & exmem_dmemREN;
      r.wen    = exmem_valid & exmem_dmemWEN & !exmem_dmemREN;
      r.regwen = exmem_regwen;
      r.halt   = exmem_halt;
      r.regsrc = exmem_regsrc;
      r.wsel   = exmem_wsel;
      r.addr   = exmem_porto;
      r.store  = exmem_rdat2;
      r.npc    = exmem_npc;
      r.imm    = exmem_extimm;
      return r;
   endfunction

   function automatic req_t cur();
      if (pend_q.size() != 0) return pend_q[0];
      return from_in();
   endfunction

   task automatic check_comb();
      req_t c;
      if (m_halt) begin
         chk("h_ren", dmemREN, 0);
         chk("h_wen", dmemWEN, 0);
         chk("h_stall", mem_stall, 0);
         return;
      end
      c = cur();
      chk("ren", dmemREN, c.ren);
      chk("wen", dmemWEN, c.wen);
      chk("stall", mem_stall, (c.ren | c.wen) & !dhit);
      if (c.ren | c.wen) chk("addr", dmemaddr, c.addr);
      if (c.wen) chk("store", dmemstore, c.store);
   endtask

   task automatic model_edge();
      req_t        c;
      bit          k;
      logic [31:0] srcv[4];
      e_valid  = 0;
      e_regwen = 0;
      if (m_halt) return;
      c = cur();
      k = flush | m_kill;
      if ((c.ren | c.wen) && !dhit) begin
         if (pend_q.size() == 0) pend_q.push_back(c);
         m_kill = k;
      end else if (pend_q.size() != 0 || exmem_valid) begin
         srcv     = '{c.addr, dmemload, c.npc, c.imm};
         e_valid  = !k;
         e_regwen = c.regwen & !k;
         if (!k) begin
            e_wsel = c.wsel;
            e_wdat = srcv[c.regsrc];
         end
         if (c.halt && !k) begin
            m_halt = 1;
            e_halt = 1;
         end
         pend_q.delete();
         m_kill = 0;
      end
   endtask

   task automatic check_regs();
      chk("valid", memwb_valid, e_valid);
      chk("regwen", memwb_regwen, e_regwen);
      chk("halt", memwb_halt, e_halt);
      if (e_valid) begin
         chk("wsel", memwb_wsel, e_wsel);
         chk("wdat", memwb_wdat, e_wdat);
      end
   endtask

   task automatic cycle();
      @(negedge CLK);
      check_comb();
      @(posedge CLK);
      model_edge();
      #1 check_regs();
   endtask

   task automatic set_idle();
      exmem_valid   = 0;
      exmem_dmemREN = 0;
      exmem_dmemWEN = 0;
      exmem_regwen  = 0;
      exmem_halt    = 0;
      exmem_porto   = 0;
      exmem_rdat2   = 0;
      exmem_extimm  = 0;
      exmem_npc     = 0;
      exmem_wsel    = 0;
      exmem_regsrc  = 0;
      flush         = 0;
      dhit          = 0;
      dmemload      = 0;
   endtask

   task automatic set_rand();
      exmem_valid   = $urandom_range(0, 3) != 0;
      exmem_dmemREN = $urandom_range(0, 2) == 0;
      exmem_dmemWEN = $urandom_range(0, 2) == 0;
      exmem_regwen  = 1'($urandom);
      exmem_halt    = $urandom_range(0, 29) == 0;
      exmem_porto   = $urandom;
      exmem_rdat2   = $urandom;
      exmem_extimm  = $urandom;
      exmem_npc     = $urandom;
      exmem_wsel    = 5'($urandom);
      exmem_regsrc  = 2'($urandom);
      flush         = $urandom_range(0, 9) == 0;
      dhit          = $urandom_range(0, 2) != 0;
      dmemload      = $urandom;
   endtask

   // Reset lands mid-cycle; enables must drop before any edge.
   task automatic do_reset();
      nRST = 0;
      #1;
      chk("rst_ren", dmemREN, 0);
      chk("rst_wen", dmemWEN, 0);
      chk("rst_valid", memwb_valid, 0);
      chk("rst_regwen", memwb_regwen, 0);
      chk("rst_halt", memwb_halt, 0);
      chk("rst_wdat", memwb_wdat, 0);
      chk("rst_wsel", memwb_wsel, 0);
`ifdef MEM_TIMEOUT_EN
      chk("rst_to", mem_timeout, 0);
`endif
      set_idle();
      pend_q.delete();
      m_kill = 0;
      m_halt = 0;
      e_valid = 0;
      e_regwen = 0;
      e_halt = 0;
      @(negedge CLK);
      nRST = 1;
      @(posedge CLK);
      model_edge();
      #1 check_regs();
   endtask

   int stalls;
   int hcnt;

   initial begin
      nRST = 0;
      set_idle();
      do_reset();

      // ALU op, one-cycle latency
      exmem_valid  = 1;
      exmem_porto  = 32'h0000_1234;
      exmem_regsrc = 0;
      exmem_wsel   = 5;
      exmem_regwen = 1;
      cycle();
      chk("alu_valid", memwb_valid, 1);
      chk("alu_wdat", memwb_wdat, 32'h1234);
      chk("alu_wsel", memwb_wsel, 5);
      set_idle();
      cycle();

      // load miss, hit on the fourth cycle
      exmem_valid   = 1;
      exmem_dmemREN = 1;
      exmem_porto   = 32'h100;
      exmem_regsrc  = 1;
      exmem_wsel    = 7;
      exmem_regwen  = 1;
      stalls = 0;
      for (int i = 0; i < 4; i++) begin
         dhit     = (i == 3);
         dmemload = (i == 3) ? 32'hDEAD_BEEF : $urandom;
         @(negedge CLK);
         check_comb();
         chk("ld_addr", dmemaddr, 32'h100);
         stalls += int'(mem_stall);
         @(posedge CLK);
         model_edge();
         #1 check_regs();
         exmem_porto   = $urandom;
         exmem_dmemREN = 1'($urandom);
         exmem_dmemWEN = 1'($urandom);
         exmem_wsel    = 5'($urandom);
         exmem_regsrc  = 2'($urandom);
      end
      chk("ld_stalls", stalls, 3);
      chk("ld_valid", memwb_valid, 1);
      chk("ld_wdat", memwb_wdat, 32'hDEAD_BEEF);
      set_idle();
      cycle();

      // store with a same-cycle hit
      exmem_valid   = 1;
      exmem_dmemWEN = 1;
      exmem_porto   = 32'h200;
      exmem_rdat2   = 32'hCAFE;
      exmem_regwen  = 0;
      dhit          = 1;
      @(negedge CLK);
      check_comb();
      chk("st_wen", dmemWEN, 1);
      chk("st_stall", mem_stall, 0);
      chk("st_data", dmemstore, 32'hCAFE);
      @(posedge CLK);
      model_edge();
      #1 check_regs();
      chk("st_regwen", memwb_regwen, 0);
      set_idle();
      @(negedge CLK);
      chk("st_wen_off", dmemWEN, 0);
      @(posedge CLK);
      model_edge();
      #1 check_regs();

      // flush in the second cycle of a four-cycle wait
      exmem_valid   = 1;
      exmem_dmemREN = 1;
      exmem_porto   = 32'h180;
      exmem_regsrc  = 1;
      exmem_regwen  = 1;
      stalls = 0;
      for (int i = 0; i < 5; i++) begin
         dhit  = (i == 4);
         flush = (i == 1);
         @(negedge CLK);
         check_comb();
         chk("fl_ren", dmemREN, 1);
         stalls += int'(mem_stall);
         @(posedge CLK);
         model_edge();
         #1 check_regs();
         flush = 0;
      end
      chk("fl_stalls", stalls, 4);
      chk("fl_valid", memwb_valid, 0);
      chk("fl_regwen", memwb_regwen, 0);
      set_idle();
      cycle();
      chk("fl_after", memwb_valid, 0);

      // halt, then a load that must be ignored
      exmem_valid = 1;
      exmem_halt  = 1;
      exmem_wsel  = 3;
      cycle();
      chk("halt_set", memwb_halt, 1);
      set_idle();
      exmem_valid   = 1;
      exmem_dmemREN = 1;
      exmem_porto   = 32'h300;
      for (int i = 0; i < 3; i++) begin
         dhit = 1'($urandom);
         @(negedge CLK);
         check_comb();
         chk("halt_ren", dmemREN, 0);
         @(posedge CLK);
         model_edge();
         #1 check_regs();
         chk("halt_hold", memwb_halt, 1);
         chk("halt_bub", memwb_valid, 0);
      end
      do_reset();

      // reset pulse while waiting on a load
      exmem_valid   = 1;
      exmem_dmemREN = 1;
      exmem_porto   = 32'h340;
      dhit          = 0;
      cycle();
      cycle();
      chk("wait_ren", dmemREN, 1);
      do_reset();
      exmem_valid  = 1;
      exmem_porto  = 32'h55;
      exmem_regwen = 1;
      cycle();
      chk("post_rst", memwb_valid, 1);
      set_idle();
      cycle();

      // random traffic
      hcnt = 0;
      for (int n = 0; n < 400; n++) begin
         set_rand();
         cycle();
         if (m_halt) hcnt++;
         if (hcnt > 3) begin
            do_reset();
            hcnt = 0;
         end
      end

`ifdef MEM_TIMEOUT_EN
      do_reset();
      exmem_valid   = 1;
      exmem_dmemREN = 1;
      exmem_porto   = 32'h400;
      dhit          = 0;
      cycle();
      for (int i = 0; i < 254; i++) cycle();
      chk("to_early", mem_timeout, 0);
      cycle();
      chk("to_set", mem_timeout, 1);
      dhit = 1;
      cycle();
      set_idle();
      cycle();
      chk("to_sticky", mem_timeout, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
